// File: rtl/decoder_xx6812_if.sv
// Bus bundle between an xx6812 line source and the decoder_xx6812 receiver.
interface decoder_xx6812_if;
  logic        serial_data_in;
  logic [23:0] parallel_data_out;
  logic        data_ready;
  logic [7:0]  led_counter;
  logic        frame_done;
  logic        error;
  logic [7:0]  error_count;

  modport master (
    output serial_data_in,
    input  parallel_data_out, data_ready, led_counter, frame_done, error, error_count
  );

  modport slave (
    input  serial_data_in,
    output parallel_data_out, data_ready, led_counter, frame_done, error, error_count
  );
endinterface

// File: rtl/decoder_xx6812.sv
// Decodes an xx6812 single-wire stream into 24-bit LED words and detects latch gaps.
// Protocol-error detection is built only when XX6812_DECODER_ERROR_EN is defined.
module decoder_xx6812 #(
  parameter int unsigned BIT_THRESHOLD = 7,
  parameter int unsigned MIN_HIGH      = 2,
  parameter int unsigned MAX_HIGH      = 14,
  parameter int unsigned LATCH_CYCLES  = 600
) (
  input  logic            clock_12mhz,
  input  logic            reset,
  decoder_xx6812_if.slave bus
);
  localparam int unsigned WORD_W   = 24;
  localparam int unsigned BCW      = 5;
  localparam int unsigned IDX_W    = 8;
  localparam int unsigned ECW      = 8;
  localparam int unsigned HIGH_SAT = MAX_HIGH + 1;
  localparam int unsigned HCW      = $clog2(HIGH_SAT + 1);
  localparam int unsigned LCW      = $clog2(LATCH_CYCLES + 1);

`ifdef XX6812_DECODER_ERROR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_HIGH, ST_LOW} state_t;

  logic [1:0]        sync_q;
  logic              s;
  logic              s_d;
  logic              rise_c;

  state_t            state, state_n;
  logic [HCW-1:0]    high_cnt, high_cnt_n;
  logic [LCW-1:0]    low_cnt, low_cnt_n;
  logic [WORD_W-1:0] shreg, shreg_n;
  logic [BCW-1:0]    bit_cnt, bit_cnt_n;
  logic [IDX_W-1:0]  word_idx, word_idx_n;
  logic [WORD_W-1:0] pdo_q, pdo_n;
  logic [IDX_W-1:0]  led_q, led_n;
  logic              dr_q, dr_n;
  logic              fd_q, fd_n;
  logic              err_q, err_n;
  logic [ECW-1:0]    err_cnt_q, err_cnt_n;
  logic              err_hit;

  logic              bit_val_c;
  logic [WORD_W-1:0] new_word_c;
  logic              bad_len_c;
  logic              partial_err_c;
  logic              latch_c;

  // Two-flop synchronizer plus one delay stage for edge detection
  always_ff @(posedge clock_12mhz or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], bus.serial_data_in};
      s_d    <= s;
    end
  end

  assign s      = sync_q[1];
  assign rise_c = s & ~s_d;

  assign bit_val_c     = (high_cnt >= HCW'(BIT_THRESHOLD));
  assign new_word_c    = {shreg[WORD_W-2:0], bit_val_c};
  assign bad_len_c     = ERR_EN && ((high_cnt < HCW'(MIN_HIGH)) || (high_cnt > HCW'(MAX_HIGH)));
  assign partial_err_c = ERR_EN && (bit_cnt != '0);
  assign latch_c       = (low_cnt == LCW'(LATCH_CYCLES));

  // Next-state and datapath update
  always_comb begin
    state_n    = state;
    high_cnt_n = high_cnt;
    low_cnt_n  = low_cnt;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    word_idx_n = word_idx;
    pdo_n      = pdo_q;
    led_n      = led_q;
    dr_n       = 1'b0;
    fd_n       = 1'b0;
    err_hit    = 1'b0;

    case (state)
      // Hold off until a full latch gap so decoding starts frame-aligned
      ST_SYNC: begin
        if (latch_c) begin
          low_cnt_n = '0;
          if (rise_c) begin
            state_n    = ST_HIGH;
            high_cnt_n = HCW'(1);
          end else begin
            state_n = ST_IDLE;
          end
        end else if (s) begin
          low_cnt_n = '0;
        end else begin
          low_cnt_n = low_cnt + LCW'(1);
        end
      end

      ST_IDLE: begin
        if (rise_c) begin
          state_n    = ST_HIGH;
          high_cnt_n = HCW'(1);
        end
      end

      ST_HIGH: begin
        if (s) begin
          if (high_cnt != HCW'(HIGH_SAT)) high_cnt_n = high_cnt + HCW'(1);
        end else begin
          low_cnt_n = LCW'(1);
          if (bad_len_c) begin
            err_hit    = 1'b1;
            state_n    = ST_SYNC;
            bit_cnt_n  = '0;
            word_idx_n = '0;
          end else begin
            state_n = ST_LOW;
            shreg_n = new_word_c;
            if (bit_cnt == BCW'(WORD_W - 1)) begin
              pdo_n      = new_word_c;
              led_n      = word_idx;
              dr_n       = 1'b1;
              bit_cnt_n  = '0;
              word_idx_n = word_idx + IDX_W'(1);
            end else begin
              bit_cnt_n = bit_cnt + BCW'(1);
            end
          end
        end
      end

      // A latch takes priority over a simultaneous rising edge
      ST_LOW: begin
        if (latch_c) begin
          fd_n       = 1'b1;
          bit_cnt_n  = '0;
          word_idx_n = '0;
          low_cnt_n  = '0;
          if (partial_err_c) begin
            err_hit   = 1'b1;
            state_n   = ST_SYNC;
            low_cnt_n = s ? LCW'(0) : LCW'(1);
          end else if (rise_c) begin
            state_n    = ST_HIGH;
            high_cnt_n = HCW'(1);
          end else begin
            state_n = ST_IDLE;
          end
        end else if (rise_c) begin
          state_n    = ST_HIGH;
          high_cnt_n = HCW'(1);
        end else begin
          low_cnt_n = low_cnt + LCW'(1);
        end
      end

      default: state_n = ST_SYNC;
    endcase

    err_n     = err_q | err_hit;
    err_cnt_n = (err_hit && (err_cnt_q != {ECW{1'b1}})) ? err_cnt_q + ECW'(1) : err_cnt_q;
  end

  always_ff @(posedge clock_12mhz or negedge reset) begin
    if (!reset) begin
      state     <= ST_SYNC;
      high_cnt  <= '0;
      low_cnt   <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      word_idx  <= '0;
      pdo_q     <= '0;
      led_q     <= '0;
      dr_q      <= 1'b0;
      fd_q      <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state     <= state_n;
      high_cnt  <= high_cnt_n;
      low_cnt   <= low_cnt_n;
      shreg     <= shreg_n;
      bit_cnt   <= bit_cnt_n;
      word_idx  <= word_idx_n;
      pdo_q     <= pdo_n;
      led_q     <= led_n;
      dr_q      <= dr_n;
      fd_q      <= fd_n;
      err_q     <= err_n;
      err_cnt_q <= err_cnt_n;
    end
  end

  assign bus.parallel_data_out = pdo_q;
  assign bus.data_ready        = dr_q;
  assign bus.led_counter       = led_q;
  assign bus.frame_done        = fd_q;
  assign bus.error             = err_q;
  assign bus.error_count       = err_cnt_q;
endmodule

// File: doc/decoder_xx6812.md
# decoder_xx6812

Receive-side counterpart of the xx6812 strip encoder. Samples a single-wire xx6812 (WS2812-style) serial stream on the 12 MHz system clock, classifies each high pulse as a 0 or 1 bit, assembles 24-bit LED words MSB-first, and detects the latch gap that ends a frame. Used for loop-back verification of the strip output and for chaining actors, where a board reads an upstream strip signal.

## Interface
- `BIT_THRESHOLD`, 7: a high-time of at least this many cycles decodes as 1; anything shorter decodes as 0.
- `MIN_HIGH`, 2: a high-time below this is a glitch.
- `MAX_HIGH`, 14: a high-time above this is overlong.
- `LATCH_CYCLES`, 600: low-time in cycles that marks a latch (frame end); 50 µs at 12 MHz.
- `clock_12mhz`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low.
- `serial_data_in`  in  1  raw strip line; asynchronous to the clock.
- `parallel_data_out`  out  24  last completed LED word, first received bit in [23].
- `data_ready`  out  1  one-cycle strobe; `parallel_data_out` and `led_counter` are valid in that cycle.
- `led_counter`  out  8  index within the frame of the word in `parallel_data_out`.
- `frame_done`  out  1  one-cycle strobe on a detected latch gap.
- `error`  out  1  sticky protocol-error flag.
- `error_count`  out  8  saturating count of protocol errors.

## Operation
- Input path: 2-flop synchronizer, then a third register for edge detection. All decode logic works on the synchronized signal `s`.
- States:
  - SYNC: after reset. Waits for `s` low for `LATCH_CYCLES`, then goes to IDLE. No strobes are issued in this state.
  - IDLE: line low between frames. A rising edge goes to HIGH.
  - HIGH: counts high cycles. A falling edge classifies the bit and goes to LOW.
  - LOW: counts low cycles. A rising edge goes to HIGH. When the low counter reaches `LATCH_CYCLES`, the block goes to IDLE and pulses `frame_done`.
- Bit shift: each bit shifts into a 24-bit shift register, and a 5-bit bit counter (0–23) increments.
  - On the 24th bit: copy the register to `parallel_data_out`, present the word index on `led_counter`, pulse `data_ready`, clear the bit counter, then increment the word index.
- Word index: 8 bits; wraps from 255 to 0 and decoding continues. `frame_done` clears it to 0.
- Counters:
  - The high counter saturates at `MAX_HIGH+1`.
  - The low counter saturates at `LATCH_CYCLES`.
  - `frame_done` fires once per gap, not repeatedly while the line stays idle.
- Latch with 1–23 bits pending: the partial word is discarded without a `data_ready`; `frame_done` still pulses.
- Rising edge in the same cycle the low counter reaches `LATCH_CYCLES`: the latch wins; `frame_done` pulses, then HIGH starts the next frame.
- Reset mid-frame: all state is cleared and the block returns to SYNC. It resumes only after a full latch gap, so it never emits a word misaligned to the frame.

## Timing
- Reset values: `parallel_data_out`=0, `data_ready`=0, `led_counter`=0, `frame_done`=0, `error`=0, `error_count`=0, state=SYNC.
- Pin-to-synchronized-signal latency: 2 cycles.
- `data_ready` is high in the cycle after the cycle in which `s` is first seen low following the 24th high pulse, i.e. 3 cycles after the pin falls.
- `frame_done` is high in the cycle after the low counter reaches `LATCH_CYCLES`.
- `data_ready` and `frame_done` are never both high in the same cycle.
- The block has no backpressure: the consumer must take the word in the `data_ready` cycle. `parallel_data_out` holds its value until the next word.

## Configuration
- Macro `XX6812_DECODER_ERROR_EN`.
- Defined: each of the following counts as one error. It sets `error`, increments `error_count` (saturating at 255), discards the partial word and sends the state machine to SYNC.
  - high-time < `MIN_HIGH` (glitch);
  - high-time > `MAX_HIGH` (overlong);
  - latch with 1–23 bits pending.
- `error` clears only on reset.
- Not defined: `error` and `error_count` are tied to 0. Every high pulse is classified only against `BIT_THRESHOLD`, and a partial word at latch is discarded silently.

## Test plan
- Reset low for 5 cycles, then a 700-cycle low gap, then 24 bits of 0xA5C3F0 (1 = 8 high/7 low, 0 = 4 high/11 low) -> one `data_ready` with `parallel_data_out`=0xA5C3F0 and `led_counter`=0, 3 cycles after the last falling pin edge.
- Gap, three words 0x000001, 0xFFFFFF, 0x123456, then a 600-cycle low -> three strobes with `led_counter` 0, 1, 2, then exactly one `frame_done`; the next frame restarts at `led_counter`=0.
- Line held low 5000 cycles after a frame -> exactly one `frame_done`.
- With `XX6812_DECODER_ERROR_EN`: 10 bits, then a 1-cycle high glitch -> `error`=1, `error_count`=1, no `data_ready`. A following gap plus a valid word decodes correctly.
- 12 bits, then a latch gap -> `frame_done` pulses, no `data_ready`; `error_count` increments only when the macro is defined.
- Reset asserted mid-word, released, then a valid word without a preceding gap -> no `data_ready` until a 600-cycle gap has been seen.
